uart_launcher: RTL and testbench

- Serial transmit stage directly downstream of the launch RAM.
- On a start pulse, reads len_i bytes from RAM addresses 0..len_i-1 and serialises each as 8N1 UART, LSB first, on tx_o.
- Exports the bit-position counter (0 = start bit, 1..8 = data bits, 9 = stop bit) and the current read address.
- Baud timing comes from an internal divider; the whole block is single-clock.

---
 rtl/uart_launcher_if.sv | 21 ++
 rtl/uart_launcher.sv | 127 ++++++++++++
 tb/tb_uart_launcher.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/uart_launcher_if.sv
// Launcher-side bus: launch control, launch-RAM read port, UART line and status.
interface uart_launcher_if;
    logic       start_i;
    logic [8:0] len_i;
    logic [7:0] l_data_i;
    logic [7:0] l_addr_o;
    logic [3:0] l_data_counter_o;
    logic       tx_o;
    logic       busy_o;
    logic       done_o;

    modport slave (
        input  start_i, len_i, l_data_i,
        output l_addr_o, l_data_counter_o, tx_o, busy_o, done_o
    );

    modport master (
        output start_i, len_i, l_data_i,
        input  l_addr_o, l_data_counter_o, tx_o, busy_o, done_o
    );
endinterface

// File: rtl/uart_launcher.sv
// Reads len bytes from the launch RAM (addresses 0..len-1) and sends each as an
// 8N1 UART frame, LSB first, with an internal baud divider.
module uart_launcher #(
    parameter int BAUD_DIV = 434
) (
    input  logic           clk_i,
    input  logic           rst_i,
    uart_launcher_if.slave bus
);
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, SHIFT, NEXT} state_e;

    state_e      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [3:0]  bit_q, bit_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [7:0]  addr_q, addr_d;
    logic [8:0]  len_q, len_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        last_byte;
    logic        baud_tc;

    // 9-bit compare so len=256 finishes at address 255 without wrapping.
    assign last_byte = ({1'b0, addr_q} + 9'd1) == len_q;
    assign baud_tc   = baud_q == BAUD_LAST;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path infers a latch.
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        addr_d  = addr_q;
        len_d   = len_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    if (bus.len_i != 9'd0) begin
                        len_d   = bus.len_i;
                        addr_d  = 8'd0;
                        busy_d  = 1'b1;
                        state_d = FETCH;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                shreg_d = bus.l_data_i;
                bit_d   = 4'd0;
                tx_d    = 1'b0;
                baud_d  = 16'd0;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (baud_tc) begin
                    baud_d = 16'd0;
                    if (bit_q == 4'd9) begin
                        done_d  = last_byte;
                        state_d = NEXT;
                    end else begin
                        bit_d = bit_q + 4'd1;
                        if (bit_q == 4'd8) begin
                            tx_d = 1'b1;
                        end else begin
                            // Data bits leave LSB first; tx is registered, so it
                            // shows the bit for the position being entered.
                            tx_d    = shreg_q[0];
                            shreg_d = {1'b0, shreg_q[7:1]};
                        end
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            NEXT: begin
                if (last_byte) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    addr_d  = addr_q + 8'd1;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            baud_q  <= 16'd0;
            bit_q   <= 4'd0;
            shreg_q <= 8'd0;
            addr_q  <= 8'd0;
            len_q   <= 9'd0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register updates from pre-edge values.
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.l_addr_o         = addr_q;
    assign bus.l_data_counter_o = bit_q;
    assign bus.tx_o             = tx_q;
    assign bus.busy_o           = busy_q;
    assign bus.done_o           = done_q;
endmodule

// File: tb/tb_uart_launcher.sv
// Self-checking bench for uart_launcher: expected per-cycle line/status waveform
// is generated from the frame rules and compared cycle by cycle.
module tb_uart_launcher;
    localparam int B = 4;

    typedef struct packed {
        logic       tx;
        logic       busy;
        logic       done;
        logic [7:0] addr;
        logic [3:0] cnt;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] ram [256];

    int n_checks = 0;
    int n_pass   = 0;

    // Values the status outputs hold while idle, updated as transfers complete.
    logic [7:0] hold_addr = 8'd0;
    logic [3:0] hold_cnt  = 4'd0;

    uart_launcher_if bus ();

    uart_launcher #(.BAUD_DIV(B)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Launch RAM: one-cycle read latency.
    always @(posedge clk) bus.l_data_i <= ram[bus.l_addr_o];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic obs_t sample();
        obs_t o;
        o.tx   = bus.tx_o;
        o.busy = bus.busy_o;
        o.done = bus.done_o;
        o.addr = bus.l_addr_o;
        o.cnt  = bus.l_data_counter_o;
        return o;
    endfunction

    task automatic check(input string tag, input int k, input obs_t exp);
        obs_t got;
        got = sample();
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s k=%0d: observed tx=%b busy=%b done=%b addr=%0d cnt=%0d, expected tx=%b busy=%b done=%b addr=%0d cnt=%0d",
                    tag, k, got.tx, got.busy, got.done, got.addr, got.cnt,
                    exp.tx, exp.busy, exp.done, exp.addr, exp.cnt);
    endtask

    function automatic obs_t mk(logic tx, logic busy, logic done, logic [7:0] addr, logic [3:0] cnt);
        obs_t o;
        o.tx = tx; o.busy = busy; o.done = done; o.addr = addr; o.cnt = cnt;
        return o;
    endfunction

    task automatic idle_cycles(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check(tag, k, mk(1'b1, 1'b0, 1'b0, hold_addr, hold_cnt));
        end
    endtask

    // Builds the expected waveform for one transfer, launches it from a negedge and
    // compares every cycle. abort_k >= 0 applies reset at that sample instead.
    task automatic run_transfer(input string tag, input int len, input int abort_k, input bit poke);
        obs_t q[$];
        int   bitpos;
        logic v;
        q.push_back(mk(1'b1, 1'b1, 1'b0, 8'd0, hold_cnt));   // FETCH
        q.push_back(mk(1'b1, 1'b1, 1'b0, 8'd0, hold_cnt));   // LOAD
        for (int i = 0; i < len; i++) begin
            for (int j = 0; j < 10 * B; j++) begin
                bitpos = j / B;
                if (bitpos == 0)      v = 1'b0;
                else if (bitpos == 9) v = 1'b1;
                else                  v = ram[i][bitpos - 1];
                q.push_back(mk(v, 1'b1, 1'b0, 8'(i), 4'(bitpos)));
            end
            q.push_back(mk(1'b1, 1'b1, (i == len - 1), 8'(i), 4'd9));  // gap after stop
            if (i != len - 1) begin
                q.push_back(mk(1'b1, 1'b1, 1'b0, 8'(i + 1), 4'd9));
                q.push_back(mk(1'b1, 1'b1, 1'b0, 8'(i + 1), 4'd9));
            end
        end
        q.push_back(mk(1'b1, 1'b0, 1'b0, 8'(len - 1), 4'd9));  // back in idle

        bus.start_i = 1'b1;
        bus.len_i   = 9'(len);
        for (int k = 0; k < q.size(); k++) begin
            @(negedge clk);
            if (k == abort_k) begin
                bus.start_i = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                hold_addr = 8'd0;
                hold_cnt  = 4'd0;
                check({tag, "_rst"}, k, mk(1'b1, 1'b0, 1'b0, 8'd0, 4'd0));
                rst = 1'b0;
                idle_cycles({tag, "_postrst"}, 8);
                return;
            end
            check(tag, k, q[k]);
            if (poke && k < q.size() - 2) begin
                bus.start_i = 1'($urandom);
                bus.len_i   = 9'($urandom_range(0, 256));
            end else begin
                bus.start_i = 1'b0;
            end
        end
        hold_addr = 8'(len - 1);
        hold_cnt  = 4'd9;
    endtask

    initial begin
        int len;
        bus.start_i = 1'b0;
        bus.len_i   = 9'd0;
        for (int i = 0; i < 256; i++) ram[i] = 8'd0;

        repeat (3) @(negedge clk);
        check("reset", 0, mk(1'b1, 1'b0, 1'b0, 8'd0, 4'd0));
        rst = 1'b0;
        idle_cycles("idle", 100);

        ram[0] = 8'hA5;
        run_transfer("a5", 1, -1, 1'b0);
        idle_cycles("after_a5", 5);

        ram[0] = 8'h01; ram[1] = 8'h80; ram[2] = 8'hFF;
        run_transfer("three", 3, -1, 1'b0);
        idle_cycles("after_three", 5);

        // Zero-length launch: done pulse only, line and busy untouched.
        bus.start_i = 1'b1;
        bus.len_i   = 9'd0;
        @(negedge clk);
        check("len0_done", 0, mk(1'b1, 1'b0, 1'b1, hold_addr, hold_cnt));
        bus.start_i = 1'b0;
        idle_cycles("len0_after", 5);

        // Reset during data bit 4 of the second byte, then relaunch from address 0.
        for (int i = 0; i < 3; i++) ram[i] = 8'($urandom);
        run_transfer("abort", 3, 2 + 10 * B + 3 + 5 * B + 1, 1'b0);
        run_transfer("relaunch", 2, -1, 1'b0);
        idle_cycles("after_relaunch", 3);

        for (int t = 0; t < 6; t++) begin
            len = $urandom_range(1, 5);
            for (int i = 0; i < len; i++) ram[i] = 8'($urandom);
            run_transfer("rand", len, -1, 1'b1);
            idle_cycles("rand_gap", $urandom_range(1, 4));
        end

        for (int i = 0; i < 256; i++) ram[i] = 8'(i);
        run_transfer("len256", 256, -1, 1'b1);
        idle_cycles("after_256", 10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
